// File: rtl/steer_en_cond.sv
// Load-cell conditioning and settle timer for the steering-enable state machine.
// Define LD_FILT_EN to average each cell over its last four samples before thresholding.
module steer_en_cond #(
   parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
   parameter logic [11:0] HYSTERESIS       = 12'h040,
   parameter logic [25:0] TMR_FULL_CNT     = 26'd65_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   input  logic        ld_vld,
   input  logic        clr_tmr,
   output logic        sum_gt_min,
   output logic        sum_lt_min,
   output logic        diff_gt_1_4,
   output logic        diff_gt_15_16,
   output logic        tmr_full
);

   if (MIN_RIDER_WEIGHT < HYSTERESIS) begin : g_bad_param
      $error("steer_en_cond: HYSTERESIS exceeds MIN_RIDER_WEIGHT");
   end

   localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
   localparam logic [12:0] THR_LO = {1'b0, MIN_RIDER_WEIGHT - HYSTERESIS};

   logic [11:0] lft_eff, rght_eff;
   logic        vld_q;

`ifdef LD_FILT_EN
   logic [11:0] lft_hist_q  [4];
   logic [11:0] rght_hist_q [4];
   logic [13:0] lft_run_q, rght_run_q;

   // Running sums track the four-entry history: add the newest, drop the oldest.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            lft_hist_q[i]  <= '0;
            rght_hist_q[i] <= '0;
         end
         lft_run_q  <= '0;
         rght_run_q <= '0;
      end else if (ld_vld) begin
         lft_run_q  <= lft_run_q + {2'b00, lft_ld} - {2'b00, lft_hist_q[3]};
         rght_run_q <= rght_run_q + {2'b00, rght_ld} - {2'b00, rght_hist_q[3]};
         for (int i = 3; i > 0; i--) begin
            lft_hist_q[i]  <= lft_hist_q[i-1];
            rght_hist_q[i] <= rght_hist_q[i-1];
         end
         lft_hist_q[0]  <= lft_ld;
         rght_hist_q[0] <= rght_ld;
      end
   end

   assign lft_eff  = lft_run_q[13:2];
   assign rght_eff = rght_run_q[13:2];
`else
   logic [11:0] lft_q, rght_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lft_q  <= '0;
         rght_q <= '0;
      end else if (ld_vld) begin
         lft_q  <= lft_ld;
         rght_q <= rght_ld;
      end
   end

   assign lft_eff  = lft_q;
   assign rght_eff = rght_q;
`endif

   logic [12:0] sum, q, f;
   logic [11:0] diff;

   always_comb begin
      sum  = {1'b0, lft_eff} + {1'b0, rght_eff};
      diff = (lft_eff >= rght_eff) ? (lft_eff - rght_eff) : (rght_eff - lft_eff);
      q    = sum >> 2;
      f    = sum - (sum >> 4);
   end

   // Flags refresh only on the cycle after a capture, otherwise they hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q         <= 1'b0;
         sum_gt_min    <= 1'b0;
         sum_lt_min    <= 1'b0;
         diff_gt_1_4   <= 1'b0;
         diff_gt_15_16 <= 1'b0;
      end else begin
         vld_q <= ld_vld;
         if (vld_q) begin
            sum_gt_min    <= sum > THR_HI;
            sum_lt_min    <= sum < THR_LO;
            diff_gt_1_4   <= {1'b0, diff} > q;
            diff_gt_15_16 <= {1'b0, diff} > f;
         end
      end
   end

   logic [25:0] tmr_cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr_tmr) begin
         tmr_cnt_q <= '0;
      end else if (tmr_cnt_q != TMR_FULL_CNT) begin
         tmr_cnt_q <= tmr_cnt_q + 26'd1;
      end
   end

   assign tmr_full = (tmr_cnt_q == TMR_FULL_CNT);

endmodule

// File: tb/tb_steer_en_cond.sv
// Randomized and directed bench for steer_en_cond against a behavioural model.
// Follows LD_FILT_EN so the model matches the build under test.
module tb_steer_en_cond;

   localparam int FULL = 16;
   localparam int MIN  = 512;
   localparam int HYST = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] lft_ld = '0;
   logic [11:0] rght_ld = '0;
   logic        ld_vld = 1'b0;
   logic        clr_tmr = 1'b0;
   logic        sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full;

   steer_en_cond #(
      .MIN_RIDER_WEIGHT(12'h200),
      .HYSTERESIS      (12'h040),
      .TMR_FULL_CNT    (26'(FULL))
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .lft_ld       (lft_ld),
      .rght_ld      (rght_ld),
      .ld_vld       (ld_vld),
      .clr_tmr      (clr_tmr),
      .sum_gt_min   (sum_gt_min),
      .sum_lt_min   (sum_lt_min),
      .diff_gt_1_4  (diff_gt_1_4),
      .diff_gt_15_16(diff_gt_15_16),
      .tmr_full     (tmr_full)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Model state: visible flags, flags pending from last capture, timer count, histories.
   logic [3:0] m_flags = '0;
   logic [3:0] m_pend  = '0;
   bit         m_pend_vld = 1'b0;
   int         m_cnt = 0;
   int         hl[4] = '{0, 0, 0, 0};
   int         hr[4] = '{0, 0, 0, 0};

   function automatic logic [3:0] flags_of(int l, int r);
      int s, d;
      s = l + r;
      d = (l > r) ? l - r : r - l;
      return {s > MIN + HYST, s < MIN - HYST, d > s / 4, d > s - s / 16};
   endfunction

   task automatic model_step();
      if (rst) begin
         m_flags    = '0;
         m_pend_vld = 1'b0;
         m_cnt      = 0;
         for (int i = 0; i < 4; i++) begin
            hl[i] = 0;
            hr[i] = 0;
         end
      end else begin
         if (m_pend_vld) m_flags = m_pend;
         m_pend_vld = ld_vld;
         if (ld_vld) begin
`ifdef LD_FILT_EN
            for (int i = 3; i > 0; i--) begin
               hl[i] = hl[i-1];
               hr[i] = hr[i-1];
            end
            hl[0] = int'(lft_ld);
            hr[0] = int'(rght_ld);
            m_pend = flags_of((hl[0] + hl[1] + hl[2] + hl[3]) / 4,
                              (hr[0] + hr[1] + hr[2] + hr[3]) / 4);
`else
            m_pend = flags_of(int'(lft_ld), int'(rght_ld));
`endif
         end
         if (clr_tmr) m_cnt = 0;
         else if (m_cnt < FULL) m_cnt++;
      end
   endtask

   task automatic tick();
      logic [4:0] got, want;
      model_step();
      @(posedge clk);
      @(negedge clk);
      if (chk_en) begin
         got  = {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full};
         want = {m_flags, m_cnt == FULL};
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got=%b want=%b", $time, got, want);
         end
      end
   endtask

   task automatic check_lit(string name, logic got, logic want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic sample(int l, int r);
      lft_ld  = 12'(l);
      rght_ld = 12'(r);
      ld_vld  = 1'b1;
      tick();
      ld_vld = 1'b0;
      tick();
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      check_lit("rst_gt", sum_gt_min, 1'b0);
      check_lit("rst_lt", sum_lt_min, 1'b0);
      check_lit("rst_tmr", tmr_full, 1'b0);

`ifndef LD_FILT_EN
      sample(300, 300);
      check_lit("above_gt", sum_gt_min, 1'b1);
      check_lit("above_lt", sum_lt_min, 1'b0);
      check_lit("above_d14", diff_gt_1_4, 1'b0);
      check_lit("above_d1516", diff_gt_15_16, 1'b0);
      sample(240, 240);
      check_lit("band_gt", sum_gt_min, 1'b0);
      check_lit("band_lt", sum_lt_min, 1'b0);
      sample(200, 200);
      check_lit("below_lt", sum_lt_min, 1'b1);
      sample(289, 288);
      check_lit("edge577_gt", sum_gt_min, 1'b1);
      sample(500, 200);
      check_lit("d300_d14", diff_gt_1_4, 1'b1);
      check_lit("d300_d1516", diff_gt_15_16, 1'b0);
      sample(690, 10);
      check_lit("d680_d14", diff_gt_1_4, 1'b1);
      check_lit("d680_d1516", diff_gt_15_16, 1'b1);
      sample(350, 350);
      check_lit("d0_d14", diff_gt_1_4, 1'b0);
      check_lit("d0_d1516", diff_gt_15_16, 1'b0);
`else
      do_reset();
      sample(400, 400);
      check_lit("filt1_lt", sum_lt_min, 1'b1);
      sample(400, 400);
      check_lit("filt2_lt", sum_lt_min, 1'b1);
      sample(400, 400);
      check_lit("filt3_gt", sum_gt_min, 1'b1);
      check_lit("filt3_lt", sum_lt_min, 1'b0);
      sample(400, 400);
      check_lit("filt4_gt", sum_gt_min, 1'b1);
`endif

      // Timer from reset release, then after a clear.
      do_reset();
      repeat (15) tick();
      check_lit("tmr_15", tmr_full, 1'b0);
      tick();
      check_lit("tmr_16", tmr_full, 1'b1);
      repeat (3) tick();
      check_lit("tmr_hold", tmr_full, 1'b1);
      clr_tmr = 1'b1;
      tick();
      clr_tmr = 1'b0;
      check_lit("tmr_clr", tmr_full, 1'b0);
      repeat (15) tick();
      check_lit("tmr_clr15", tmr_full, 1'b0);
      tick();
      check_lit("tmr_clr16", tmr_full, 1'b1);

      do_reset();
      repeat (5) tick();
      clr_tmr = 1'b1;
      tick();
      clr_tmr = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         check_lit("tmr_mid_early", tmr_full, 1'b0);
      end
      tick();
      check_lit("tmr_mid_full", tmr_full, 1'b1);

      // Reset mid-operation with a sample offered during reset.
      do_reset();
      repeat (4) sample(300, 300);
      repeat (10) tick();
      check_lit("pre_rst_gt", sum_gt_min, 1'b1);
      check_lit("pre_rst_tmr", tmr_full, 1'b1);
      rst = 1'b1;
      ld_vld = 1'b1;
      lft_ld = 12'd690;
      rght_ld = 12'd10;
      tick();
      rst = 1'b0;
      ld_vld = 1'b0;
      check_lit("post_rst_gt", sum_gt_min, 1'b0);
      check_lit("post_rst_tmr", tmr_full, 1'b0);
      tick();
      check_lit("rst_vld_ign_d1516", diff_gt_15_16, 1'b0);
      check_lit("rst_vld_ign_d14", diff_gt_1_4, 1'b0);

      for (int i = 0; i < 4000; i++) begin
         lft_ld  = 12'($urandom_range(0, 800));
         rght_ld = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 40))
                                               : 12'($urandom_range(0, 800));
         ld_vld  = ($urandom_range(0, 2) == 0);
         clr_tmr = ($urandom_range(0, 24) == 0);
         rst     = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      ld_vld = 1'b0;
      clr_tmr = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
